// File: rtl/mosaic_pkg.sv
// Shared definitions for the mosaic line fetcher: FSM encoding, default
// display/mosaic geometry and the read-slot rewind rule.
package mosaic_pkg;

    localparam int DEF_H_WIDTH    = 800;
    localparam int DEF_V_WIDTH    = 600;
    localparam int DEF_SRC_STRIDE = 800;
    localparam int DEF_TILES_X    = 2;
    localparam int DEF_TILES_Y    = 2;
    localparam int DEF_DECIM      = 2;
    localparam int DEF_SLOT_SHIFT = 21;
    localparam int DEF_MAX_OUTST  = 64;

    localparam int LINE_W = 11;
    localparam int SLOT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FETCH = 2'd2,
        ST_GAP   = 2'd3
    } fetch_state_e;

    // The reader trails the producer by one slot so it never reads a frame being written.
    function automatic logic [SLOT_W-1:0] slot_rewind(input logic [SLOT_W-1:0] wr_slot,
                                                      input logic [SLOT_W-1:0] mask);
        return (wr_slot - SLOT_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/mosaic_addr_gen.sv
// Combinational mapping from display pixel (h, v) to the DDR word address of the
// decimated source pixel inside the owning tile's current read slot.
module mosaic_addr_gen
    import mosaic_pkg::*;
#(
    parameter int H_WIDTH    = DEF_H_WIDTH,
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int SRC_STRIDE = DEF_SRC_STRIDE,
    parameter int TILES_X    = DEF_TILES_X,
    parameter int TILES_Y    = DEF_TILES_Y,
    parameter int DECIM      = DEF_DECIM,
    parameter int SLOT_SHIFT = DEF_SLOT_SHIFT
) (
    input  logic [LINE_W-1:0]                     h_i,
    input  logic [LINE_W-1:0]                     v_i,
    input  logic [TILES_X*TILES_Y*SLOT_W-1:0]     slots_i,
    input  logic [TILES_X*TILES_Y*32-1:0]         bases_i,
    output logic [31:0]                           addr_o
);

    localparam int          NT       = TILES_X * TILES_Y;
    localparam int unsigned TW       = H_WIDTH / TILES_X;
    localparam int unsigned TH       = V_WIDTH / TILES_Y;
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << SLOT_SHIFT) - 64'd1);

    logic [31:0]       tx, ty, lx, ly, tile, off, base;
    logic [SLOT_W-1:0] slot;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        base = '0;
        slot = '0;
        tx   = 32'(h_i) / TW;
        ty   = 32'(v_i) / TH;
        lx   = 32'(h_i) - tx * TW;
        ly   = 32'(v_i) - ty * TH;
        tile = ty * TILES_X + tx;
        off  = (ly * DECIM * SRC_STRIDE + lx * DECIM) & OFF_MASK;
        for (int i = 0; i < NT; i++) begin
            if (tile == 32'(i)) begin
                base = bases_i[i*32 +: 32];
                slot = slots_i[i*SLOT_W +: SLOT_W];
            end
        end
        addr_o = base + (32'(slot) << SLOT_SHIFT) + off;
    end

endmodule

// File: rtl/mosaic_line_fetcher.sv
// Line prefetcher for a tiled camera mosaic: walks one display line per line_start
// and issues DDR word reads into the per-tile frame slot trailing the producer.
module mosaic_line_fetcher
    import mosaic_pkg::*;
#(
    parameter int H_WIDTH    = DEF_H_WIDTH,
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int SRC_STRIDE = DEF_SRC_STRIDE,
    parameter int TILES_X    = DEF_TILES_X,
    parameter int TILES_Y    = DEF_TILES_Y,
    parameter int DECIM      = DEF_DECIM,
    parameter int SLOT_SHIFT = DEF_SLOT_SHIFT,
    parameter int MAX_OUTST  = DEF_MAX_OUTST
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic                                  frame_start,
    input  logic                                  line_start,
    input  logic [LINE_W-1:0]                     line_num,
    input  logic [TILES_X*TILES_Y*32-1:0]         tile_base,
    input  logic [TILES_X*TILES_Y*SLOT_W-1:0]     tile_wr_slot,
    input  logic [TILES_X*TILES_Y*SLOT_W-1:0]     tile_slot_mask,
    output logic [31:0]                           DDR_READ_ADDR,
    output logic                                  DDR_READ_REQ,
    input  logic                                  DDR_READ_READY,
    input  logic                                  DDR_READ_DATA_VALID,
    output logic                                  line_done,
    output logic                                  overrun,
    output logic [7:0]                            outstanding
);

    localparam int                NT     = TILES_X * TILES_Y;
    localparam logic [LINE_W-1:0] H_LAST = LINE_W'(H_WIDTH - 1);
    localparam logic [LINE_W-1:0] V_LIM  = LINE_W'(V_WIDTH);
    localparam logic [7:0]        MAX_O  = 8'(MAX_OUTST);

    fetch_state_e             state_q, state_d;
    logic [LINE_W-1:0]        h_q, h_d, v_q, v_d;
    logic [NT*SLOT_W-1:0]     slot_q, slot_d;
    logic [7:0]               outst_q, outst_d;
    logic                     overrun_q, overrun_d;
    logic                     line_done_q, line_done_d;
    logic                     accept, line_ok;
    logic [31:0]              addr;

    mosaic_addr_gen #(
        .H_WIDTH    (H_WIDTH),
        .V_WIDTH    (V_WIDTH),
        .SRC_STRIDE (SRC_STRIDE),
        .TILES_X    (TILES_X),
        .TILES_Y    (TILES_Y),
        .DECIM      (DECIM),
        .SLOT_SHIFT (SLOT_SHIFT)
    ) u_addr_gen (
        .h_i     (h_q),
        .v_i     (v_q),
        .slots_i (slot_q),
        .bases_i (tile_base),
        .addr_o  (addr)
    );

    assign DDR_READ_REQ  = (state_q == ST_FETCH) && (outst_q < MAX_O);
    assign DDR_READ_ADDR = (state_q == ST_FETCH) ? addr : '0;
    assign accept        = DDR_READ_REQ && DDR_READ_READY;
    assign line_ok       = line_num < V_LIM;
    assign line_done     = line_done_q;
    assign overrun       = overrun_q;
    assign outstanding   = outst_q;

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        slot_d      = slot_q;
        outst_d     = outst_q;
        overrun_d   = overrun_q;
        line_done_d = 1'b0;

        // Slots follow frame_start in every state, so a mid-line frame switch takes effect at once.
        if (frame_start) begin
            for (int i = 0; i < NT; i++) begin
                slot_d[i*SLOT_W +: SLOT_W] = slot_rewind(tile_wr_slot[i*SLOT_W +: SLOT_W],
                                                         tile_slot_mask[i*SLOT_W +: SLOT_W]);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (line_start) begin
                    if (line_ok) begin
                        state_d = ST_FETCH;
                        h_d     = '0;
                        v_d     = line_num;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FETCH, ST_GAP: begin
                if (line_start) begin
                    // A new line before the previous one finished: drop it and restart.
                    overrun_d = 1'b1;
                    if (line_ok) begin
                        state_d = ST_FETCH;
                        h_d     = '0;
                        v_d     = line_num;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (state_q == ST_GAP) begin
                    state_d = ST_ARM;
                end else if (accept) begin
                    if (h_q == H_LAST) begin
                        state_d     = ST_GAP;
                        h_d         = '0;
                        line_done_d = 1'b1;
                    end else begin
                        h_d = h_q + LINE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({accept, DDR_READ_DATA_VALID})
            2'b10:   outst_d = outst_q + 8'd1;
            2'b01:   if (outst_q != 8'd0) outst_d = outst_q - 8'd1;
            default: outst_d = outst_q;
        endcase
        if (DDR_READ_DATA_VALID && (outst_q == 8'd0)) overrun_d = 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            slot_q      <= '0;
            outst_q     <= '0;
            overrun_q   <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            slot_q      <= slot_d;
            outst_q     <= outst_d;
            overrun_q   <= overrun_d;
            line_done_q <= line_done_d;
        end
    end

endmodule

// File: doc/mosaic_line_fetcher.md
MOSAIC_LINE_FETCHER -- requirements
Module: mosaic_line_fetcher

Interface
REQ-001 The block SHALL have the parameter H_WIDTH, default 800, giving display pixels per line.
REQ-002 The block SHALL have the parameter V_WIDTH, default 600, giving display lines per frame.
REQ-003 The block SHALL have the parameter SRC_STRIDE, default 800, giving source pixels per camera line.
REQ-004 The block SHALL have the parameter TILES_X, default 2, giving mosaic columns.
REQ-005 The block SHALL have the parameter TILES_Y, default 2, giving mosaic rows; NT = TILES_X*TILES_Y.
REQ-006 The block SHALL have the parameter DECIM, default 2, giving the source subsample factor applied to x and y.
REQ-007 The block SHALL have the parameter SLOT_SHIFT, default 21, giving the log2 of the frame-slot size in words.
REQ-008 The block SHALL have the parameter MAX_OUTST, default 64, giving the maximum number of read requests in flight.
REQ-009 The block SHALL have the port sys_clk, input, 1 bit, the only clock; all logic is rising-edge.
REQ-010 The block SHALL have the port sys_rst, input, 1 bit, a synchronous active-high reset.
REQ-011 The block SHALL have the port frame_start, input, 1 bit, a one-cycle pulse marking the start of a new display frame.
REQ-012 The block SHALL have the port line_start, input, 1 bit, a one-cycle pulse requesting prefetch of line line_num.
REQ-013 The block SHALL have the port line_num, input, 11 bits, the display line to fetch, sampled with line_start.
REQ-014 The block SHALL have the port tile_base, input, NT*32 bits, the per-tile DDR base word address; tile t occupies [32t+31:32t].
REQ-015 The block SHALL have the port tile_wr_slot, input, NT*6 bits, the producer's current write slot per tile.
REQ-016 The block SHALL have the port tile_slot_mask, input, NT*6 bits, the per-tile slot wrap mask (0x03 = 4 slots, 0x01 = 2 slots).
REQ-017 The block SHALL have the port DDR_READ_ADDR, output, 32 bits, the read word address.
REQ-018 The block SHALL have the port DDR_READ_REQ, output, 1 bit, the read request.
REQ-019 The block SHALL have the port DDR_READ_READY, input, 1 bit; a request is accepted in any cycle where REQ && READY.
REQ-020 The block SHALL have the port DDR_READ_DATA_VALID, input, 1 bit, marking one returned word.
REQ-021 The block SHALL have the port line_done, output, 1 bit, a one-cycle pulse issued after the last request of a line is accepted.
REQ-022 The block SHALL have the port overrun, output, 1 bit, a sticky flag cleared only by reset.
REQ-023 The block SHALL have the port outstanding, output, 8 bits, the count of in-flight reads.

Function
REQ-024 On frame_start, each tile's read slot SHALL latch (tile_wr_slot[t]-1) & tile_slot_mask[t], and the FSM SHALL enter ARM from IDLE.
REQ-025 The FSM SHALL have the states IDLE, ARM, FETCH and GAP; IDLE->ARM on frame_start; ARM->FETCH on line_start with line_num<V_WIDTH; FETCH->GAP on acceptance of pixel h=H_WIDTH-1; GAP->ARM after exactly 1 cycle; ARM->IDLE on line_start with line_num>=V_WIDTH.
REQ-026 In FETCH, pixel counter h SHALL start at 0 and advance by one per accepted request only.
REQ-027 With TW=H_WIDTH/TILES_X and TH=V_WIDTH/TILES_Y, the address SHALL use tx=h/TW, ty=v/TH, t=ty*TILES_X+tx, lx=h-tx*TW and ly=v-ty*TH.
REQ-028 DDR_READ_ADDR SHALL equal tile_base[t] + (slot[t]<<SLOT_SHIFT) + (((ly*DECIM)*SRC_STRIDE + lx*DECIM) mod 2^SLOT_SHIFT), computed in 32-bit wrap-around arithmetic.
REQ-029 DDR_READ_ADDR SHALL be valid in the same cycle as DDR_READ_REQ and held stable while DDR_READ_REQ=1 and READY=0.
REQ-030 DDR_READ_REQ SHALL be 1 only in FETCH and only when outstanding<MAX_OUTST.
REQ-031 outstanding SHALL increment on acceptance, decrement on DATA_VALID, remain unchanged when both occur in the same cycle, and never underflow; a DATA_VALID seen at 0 SHALL set overrun.
REQ-032 A line_start received in FETCH or GAP SHALL set overrun, abandon the current line without line_done, and restart FETCH at h=0 for the new line_num.
REQ-033 A frame_start received mid-line SHALL update the slots immediately, and the remaining pixels of that line SHALL use the new slots.
REQ-034 line_done SHALL pulse in the cycle after the final acceptance.

Reset
REQ-035 While sys_rst=1: FSM=IDLE, h=0, outstanding=0, all slots=0, DDR_READ_REQ=0, DDR_READ_ADDR=0, line_done=0, overrun=0.
REQ-036 Reset SHALL take priority over every other input, including mid-FETCH.

Structure
REQ-037 The FSM state enumeration and the default geometry constants SHALL live in the shared package mosaic_pkg.
REQ-038 The address computation SHALL be a sub-module, mosaic_addr_gen, that is combinational from (h, v, slots, bases) to address.

Verification
REQ-039 Scenario: defaults, tile_wr_slot[0]=5, frame_start, line_start with line_num=0, READY=1 -> the first address is 0x0080_0000 + base0 and h=1 gives base0+0x0080_0002.
REQ-040 Scenario: line_num=300, h=400 (tile 3, mask 0x01, wr_slot 0) -> slot=1 and the address is base3 + 0x20_0000 + 0 + 0.
REQ-041 Scenario: READY held 0 for 5 cycles mid-line -> the address is stable, h is frozen, and exactly 800 acceptances occur followed by one line_done.
REQ-042 Scenario: DATA_VALID never returns and MAX_OUTST=64 -> REQ drops after 64 acceptances, and outstanding=64.
REQ-043 Scenario: line_start at h=100 -> overrun=1, no line_done, and the new line restarts at h=0.
REQ-044 Scenario: sys_rst asserted mid-FETCH -> the next cycle REQ=0, outstanding=0 and state IDLE.
